// File: rtl/host_stream_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : host_stream_driver_if
// Purpose  : Bundles the device data channel (con_*), the bus-ownership flag
//            and the shared kernel/input memory read port used by
//            host_stream_driver.
// Members  : con_valid, con_ready, con_data, host_drives,
//            mem_rd_en, mem_sel, mem_rd_addr, mem_rd_data
// Modports : master - the stream driver (drives con_*, host_drives, mem read
//                     request; receives con_ready and mem_rd_data)
//            slave  - the device/memory side
// Revision : 1.0 - initial release
// ============================================================================
interface host_stream_driver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 20
);
  logic                  con_valid;
  logic                  con_ready;
  logic [DATA_WIDTH-1:0] con_data;
  logic                  host_drives;
  logic                  mem_rd_en;
  logic                  mem_sel;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output con_valid, con_data, host_drives, mem_rd_en, mem_sel, mem_rd_addr,
    input  con_ready, mem_rd_data
  );

  modport slave (
    input  con_valid, con_data, host_drives, mem_rd_en, mem_sel, mem_rd_addr,
    output con_ready, mem_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/host_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : host_stream_driver
// Purpose  : Streams kernel and input-feature words from two 1-cycle-latency
//            memories to the convolution device in its fixed burst schedule.
//            Only the first word of a kernel or row-prime burst waits for
//            con_ready; all other words go out on fixed cycles.
// Ports    : clk        - clock
//            arst_n_in  - asynchronous active-low reset
//            start      - begin a run (sampled only while idle)
//            running    - high whenever not idle
//            done       - one-cycle pulse in the last cycle of a run
//            proto_err  - sticky: device not ready on an unhandshaked word
//            bus        - data channel + memory read port (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module host_stream_driver #(
  parameter int K_BURSTS     = 6,
  parameter int K_WORDS      = 12,
  parameter int PRIME_BURSTS = 3,
  parameter int I_WORDS      = 4,
  parameter int X_COUNT      = 64,
  parameter int Y_COUNT      = 64,
  parameter int CH_GROUPS    = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_W       = 20
) (
  input  wire logic             clk,
  input  wire logic             arst_n_in,
  input  wire logic             start,
  output logic                  running,
  output logic                  done,
  output logic                  proto_err,
  host_stream_driver_if.master  bus
);

  // Counter widths; a loop of one iteration still gets a 1-bit counter.
  localparam int c_wmax = (K_WORDS > I_WORDS) ? K_WORDS : I_WORDS;
  localparam int c_ww   = (c_wmax > 1)       ? $clog2(c_wmax)       : 1;
  localparam int c_bw   = (K_BURSTS > 1)     ? $clog2(K_BURSTS)     : 1;
  localparam int c_pw   = (PRIME_BURSTS > 1) ? $clog2(PRIME_BURSTS) : 1;
  localparam int c_xw   = (X_COUNT > 1)      ? $clog2(X_COUNT)      : 1;
  localparam int c_yw   = (Y_COUNT > 1)      ? $clog2(Y_COUNT)      : 1;
  localparam int c_gw   = (CH_GROUPS > 1)    ? $clog2(CH_GROUPS)    : 1;

  localparam logic [c_ww-1:0] c_kw_last  = c_ww'(K_WORDS - 1);
  localparam logic [c_ww-1:0] c_iw_last  = c_ww'(I_WORDS - 1);
  localparam logic [c_bw-1:0] c_b_last   = c_bw'(K_BURSTS - 1);
  localparam logic [c_pw-1:0] c_p_last   = c_pw'(PRIME_BURSTS - 1);
  localparam logic [c_xw-1:0] c_x_last   = c_xw'(X_COUNT - 1);
  localparam logic [c_yw-1:0] c_y_last   = c_yw'(Y_COUNT - 1);
  localparam logic [c_gw-1:0] c_grp_last = c_gw'(CH_GROUPS - 1);

  // Address strides. Each input row holds its prime words followed by the
  // compute words of every x position.
  localparam logic [ADDR_W-1:0] c_k_words    = ADDR_W'(K_WORDS);
  localparam logic [ADDR_W-1:0] c_k_grp_step = ADDR_W'(K_BURSTS * K_WORDS);
  localparam logic [ADDR_W-1:0] c_i_words    = ADDR_W'(I_WORDS);
  localparam logic [ADDR_W-1:0] c_row_words  = ADDR_W'(I_WORDS * (PRIME_BURSTS + X_COUNT));
  localparam logic [ADDR_W-1:0] c_comp_base  = ADDR_W'(PRIME_BURSTS * I_WORDS);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_K_HEAD = 4'd1,
    S_K_BODY = 4'd2,
    S_I_HEAD = 4'd3,
    S_I_BODY = 4'd4,
    S_I_GAP  = 4'd5,
    S_C_BODY = 4'd6,
    S_C_GAP1 = 4'd7,
    S_C_GAP2 = 4'd8
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_gw-1:0] r_grp, w_grp_nxt;
  logic [c_bw-1:0] r_b,   w_b_nxt;
  logic [c_pw-1:0] r_p,   w_p_nxt;
  logic [c_yw-1:0] r_y,   w_y_nxt;
  logic [c_xw-1:0] r_x,   w_x_nxt;
  logic [c_ww-1:0] r_w,   w_w_nxt;

  logic                  w_start;
  logic                  w_rd_en;
  logic                  w_rd_sel;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [ADDR_W-1:0]     w_kern_addr;
  logic [ADDR_W-1:0]     w_prime_addr;
  logic [ADDR_W-1:0]     w_comp_addr;
  logic                  w_con_valid;
  logic                  w_host_drives;
  logic                  w_body;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_con_data;

  logic                  r_rd_pending;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic                  r_proto_err;

  // A start that coincides with reset must not leak a read onto the bus.
  assign w_start = start & arst_n_in;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_w     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grp   <= w_grp_nxt;
      r_b     <= w_b_nxt;
      r_p     <= w_p_nxt;
      r_y     <= w_y_nxt;
      r_x     <= w_x_nxt;
      r_w     <= w_w_nxt;
    end
  end

  // Next state and counters. The read issued in a cycle always fetches the
  // word that the *next* state/counter values will present.
  always_comb begin
    w_state_nxt   = r_state;
    w_grp_nxt     = r_grp;
    w_b_nxt       = r_b;
    w_p_nxt       = r_p;
    w_y_nxt       = r_y;
    w_x_nxt       = r_x;
    w_w_nxt       = r_w;
    w_rd_en       = 1'b0;
    w_rd_sel      = 1'b0;
    w_con_valid   = 1'b0;
    w_host_drives = 1'b0;
    w_body        = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_K_HEAD;
          w_rd_en     = 1'b1;
        end
      end

      S_K_HEAD: begin
        w_con_valid   = 1'b1;
        w_host_drives = 1'b1;
        if (bus.con_ready) begin
          w_state_nxt = S_K_BODY;
          w_w_nxt     = c_ww'(1);
          w_rd_en     = 1'b1;
        end
      end

      S_K_BODY: begin
        w_con_valid   = 1'b1;
        w_host_drives = 1'b1;
        w_body        = 1'b1;
        w_rd_en       = 1'b1;
        if (r_w == c_kw_last) begin
          w_w_nxt = '0;
          if (r_b == c_b_last) begin
            // Kernels done: first prime burst of row 0 follows.
            w_b_nxt     = '0;
            w_p_nxt     = '0;
            w_y_nxt     = '0;
            w_state_nxt = S_I_HEAD;
            w_rd_sel    = 1'b1;
          end else begin
            w_b_nxt     = r_b + c_bw'(1);
            w_state_nxt = S_K_HEAD;
          end
        end else begin
          w_w_nxt = r_w + c_ww'(1);
        end
      end

      S_I_HEAD: begin
        w_con_valid   = 1'b1;
        w_host_drives = 1'b1;
        if (bus.con_ready) begin
          w_state_nxt = S_I_BODY;
          w_w_nxt     = c_ww'(1);
          w_rd_en     = 1'b1;
          w_rd_sel    = 1'b1;
        end
      end

      S_I_BODY: begin
        w_con_valid   = 1'b1;
        w_host_drives = 1'b1;
        w_body        = 1'b1;
        if (r_w == c_iw_last) begin
          w_w_nxt     = '0;
          w_state_nxt = S_I_GAP;
        end else begin
          w_w_nxt  = r_w + c_ww'(1);
          w_rd_en  = 1'b1;
          w_rd_sel = 1'b1;
        end
      end

      S_I_GAP: begin
        w_host_drives = 1'b1;
        w_rd_en       = 1'b1;
        w_rd_sel      = 1'b1;
        if (r_p == c_p_last) begin
          w_p_nxt     = '0;
          w_x_nxt     = '0;
          w_state_nxt = S_C_BODY;
        end else begin
          w_p_nxt     = r_p + c_pw'(1);
          w_state_nxt = S_I_HEAD;
        end
      end

      S_C_BODY: begin
        w_con_valid   = 1'b1;
        w_host_drives = 1'b1;
        w_body        = 1'b1;
        if (r_w == c_iw_last) begin
          w_w_nxt     = '0;
          w_state_nxt = S_C_GAP1;
        end else begin
          w_w_nxt  = r_w + c_ww'(1);
          w_rd_en  = 1'b1;
          w_rd_sel = 1'b1;
        end
      end

      // Device drives the shared bus during both gap cycles.
      S_C_GAP1: begin
        w_state_nxt = S_C_GAP2;
      end

      S_C_GAP2: begin
        if (r_x != c_x_last) begin
          w_x_nxt     = r_x + c_xw'(1);
          w_state_nxt = S_C_BODY;
          w_rd_en     = 1'b1;
          w_rd_sel    = 1'b1;
        end else begin
          w_x_nxt = '0;
          if (r_y != c_y_last) begin
            w_y_nxt     = r_y + c_yw'(1);
            w_p_nxt     = '0;
            w_state_nxt = S_I_HEAD;
            w_rd_en     = 1'b1;
            w_rd_sel    = 1'b1;
          end else begin
            w_y_nxt = '0;
            if (r_grp != c_grp_last) begin
              w_grp_nxt   = r_grp + c_gw'(1);
              w_b_nxt     = '0;
              w_state_nxt = S_K_HEAD;
              w_rd_en     = 1'b1;
            end else begin
              w_grp_nxt   = '0;
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read addresses are formed from the next counter values.
  assign w_kern_addr  = ADDR_W'(w_grp_nxt) * c_k_grp_step
                      + ADDR_W'(w_b_nxt) * c_k_words
                      + ADDR_W'(w_w_nxt);
  assign w_prime_addr = ADDR_W'(w_y_nxt) * c_row_words
                      + ADDR_W'(w_p_nxt) * c_i_words
                      + ADDR_W'(w_w_nxt);
  assign w_comp_addr  = ADDR_W'(w_y_nxt) * c_row_words
                      + c_comp_base
                      + ADDR_W'(w_x_nxt) * c_i_words
                      + ADDR_W'(w_w_nxt);

  always_comb begin
    w_rd_addr = w_kern_addr;
    if (w_rd_sel) begin
      w_rd_addr = (w_state_nxt == S_C_BODY) ? w_comp_addr : w_prime_addr;
    end
  end

  // The word on the bus is the memory output right after a read, otherwise
  // the last captured word (keeps a stalled head stable).
  assign w_con_data = r_rd_pending ? bus.mem_rd_data : r_data_hold;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_rd_pending <= 1'b0;
      r_data_hold  <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_en;
      r_data_hold  <= w_con_data;
      if (w_body && !bus.con_ready) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign running         = (r_state != S_IDLE);
  assign done            = w_done;
  assign proto_err       = r_proto_err;
  assign bus.con_valid   = w_con_valid;
  assign bus.host_drives = w_host_drives;
  assign bus.con_data    = w_con_data;
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_sel     = w_rd_sel;
  assign bus.mem_rd_addr = w_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_host_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_stream_driver
// Purpose  : Self-checking bench for host_stream_driver. Two instances:
//            dut_a (X=2, Y=1, G=1) for the minimal run, start-hold, reset,
//            head backpressure and proto_err; dut_b (X=2, Y=2, G=2) for
//            counter wrap. Expected streams are built from the burst
//            schedule; memories return a tagged word per address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_stream_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n;
  logic start_a, start_b;
  logic ready;
  logic use_b;
  logic running_a, running_b, done_a, done_b, proto_a, proto_b;

  int n_checks;
  int n_errors;

  host_stream_driver_if #(.DATA_WIDTH(16), .ADDR_W(20)) bus_a ();
  host_stream_driver_if #(.DATA_WIDTH(16), .ADDR_W(20)) bus_b ();

  host_stream_driver #(.X_COUNT(2), .Y_COUNT(1), .CH_GROUPS(1)) dut_a (
    .clk(clk), .arst_n_in(arst_n), .start(start_a),
    .running(running_a), .done(done_a), .proto_err(proto_a), .bus(bus_a)
  );

  host_stream_driver #(.X_COUNT(2), .Y_COUNT(2), .CH_GROUPS(2)) dut_b (
    .clk(clk), .arst_n_in(arst_n), .start(start_b),
    .running(running_b), .done(done_b), .proto_err(proto_b), .bus(bus_b)
  );

  assign bus_a.con_ready = ready;
  assign bus_b.con_ready = ready;

  // Kernel words are tagged 0xA---, input words 0x5---.
  function automatic logic [15:0] memw(input logic sel, input logic [19:0] addr);
    return {(sel ? 4'h5 : 4'hA), addr[11:0]};
  endfunction

  // External memories: 1-cycle latency, junk when not reading.
  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rd_data <= memw(bus_a.mem_sel, bus_a.mem_rd_addr);
    else                 bus_a.mem_rd_data <= 16'hDEAD;
    if (bus_b.mem_rd_en) bus_b.mem_rd_data <= memw(bus_b.mem_sel, bus_b.mem_rd_addr);
    else                 bus_b.mem_rd_data <= 16'hDEAD;
  end

  // Observation mux over the instance under test.
  logic        o_run, o_done, o_valid, o_drives, o_rd, o_sel, o_proto;
  logic [15:0] o_data;
  logic [19:0] o_addr;
  assign o_run    = use_b ? running_b         : running_a;
  assign o_done   = use_b ? done_b            : done_a;
  assign o_proto  = use_b ? proto_b           : proto_a;
  assign o_valid  = use_b ? bus_b.con_valid   : bus_a.con_valid;
  assign o_drives = use_b ? bus_b.host_drives : bus_a.host_drives;
  assign o_rd     = use_b ? bus_b.mem_rd_en   : bus_a.mem_rd_en;
  assign o_sel    = use_b ? bus_b.mem_sel     : bus_a.mem_sel;
  assign o_data   = use_b ? bus_b.con_data    : bus_a.con_data;
  assign o_addr   = use_b ? bus_b.mem_rd_addr : bus_a.mem_rd_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle stream, index = cycles after the start cycle.
  logic        exp_v    [0:511];
  logic        exp_d    [0:511];
  logic        exp_sel  [0:511];
  logic [19:0] exp_addr [0:511];
  int          exp_n;

  task automatic put(input logic v, input logic d, input logic sel, input int addr);
    exp_n++;
    exp_v[exp_n]    = v;
    exp_d[exp_n]    = d;
    exp_sel[exp_n]  = sel;
    exp_addr[exp_n] = 20'(addr);
  endtask

  task automatic build_exp(input int xc, input int yc, input int gc);
    int row;
    row = 4 * (3 + xc);
    for (int k = 0; k < 512; k++) begin
      exp_v[k] = 1'b0; exp_d[k] = 1'b0; exp_sel[k] = 1'b0; exp_addr[k] = '0;
    end
    exp_n = 0;
    for (int g = 0; g < gc; g++) begin
      for (int k = 0; k < 72; k++) put(1'b1, 1'b1, 1'b0, g * 72 + k);
      for (int y = 0; y < yc; y++) begin
        for (int p = 0; p < 3; p++) begin
          for (int w = 0; w < 4; w++) put(1'b1, 1'b1, 1'b1, y * row + p * 4 + w);
          put(1'b0, 1'b1, 1'b0, 0);
        end
        for (int x = 0; x < xc; x++) begin
          for (int w = 0; w < 4; w++) put(1'b1, 1'b1, 1'b1, y * row + 12 + x * 4 + w);
          put(1'b0, 1'b0, 1'b0, 0);
          put(1'b0, 1'b0, 1'b0, 0);
        end
      end
    end
  endtask

  // Runs one full stream with con_ready high and compares every cycle.
  // With hold set, start stays high; the cycle after done must restart.
  task automatic run_stream(input logic b, input logic hold, input string tag);
    int          len;
    logic        rd_exp;
    logic [20:0] rd_tgt;
    len   = exp_n;
    use_b = b;
    ready = 1'b1;
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    #1;
    check({tag, " c0 read"}, {o_rd, o_sel, o_addr}, {1'b1, exp_sel[1], exp_addr[1]});
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c < len) begin
        rd_exp = exp_v[c + 1];
        rd_tgt = {exp_sel[c + 1], exp_addr[c + 1]};
      end else if (c == len) begin
        rd_exp = 1'b0;
        rd_tgt = '0;
      end else begin
        rd_exp = hold;
        rd_tgt = {exp_sel[1], exp_addr[1]};
      end
      check($sformatf("%s c%0d run/done/valid/drives/rd", tag, c),
            {o_run, o_done, o_valid, o_drives, o_rd},
            {(c <= len), (c == len), exp_v[c], exp_d[c], rd_exp});
      if (exp_v[c]) check($sformatf("%s c%0d data", tag, c), o_data, memw(exp_sel[c], exp_addr[c]));
      if (rd_exp)   check($sformatf("%s c%0d read", tag, c), {o_sel, o_addr}, rd_tgt);
      check($sformatf("%s c%0d proto_err", tag, c), o_proto, 1'b0);
      if (!hold && c == 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic seen;
    n_checks = 0;
    n_errors = 0;
    use_b    = 1'b0;
    ready    = 1'b1;
    arst_n   = 1'b0;
    start_a  = 1'b1;   // start during reset must stay without effect
    start_b  = 1'b1;
    exp_n    = 0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst a status", {o_run, o_done, o_valid, o_drives, o_rd, o_proto}, 6'b0);
    check("rst a data", o_data, 16'h0);
    use_b = 1'b1;
    #1;
    check("rst b status", {o_run, o_done, o_valid, o_drives, o_rd, o_proto}, 6'b0);
    use_b   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle a after reset", {o_run, o_rd}, 2'b00);

    // Minimal run X=2 Y=1 G=1: 99 cycles, done in the last.
    build_exp(2, 1, 1);
    run_stream(1'b0, 1'b0, "min");
    repeat (2) @(negedge clk);

    // Same run with start held high throughout, then a clean restart.
    run_stream(1'b0, 1'b1, "hold");
    @(negedge clk);
    check("restart K_HEAD status", {o_run, o_valid, o_drives, o_rd}, 4'b1111);
    check("restart K_HEAD data", o_data, 16'hA000);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    check("restart K_BODY w2 data", o_data, 16'hA002);

    // Asynchronous reset in the middle of K_BODY.
    #2 arst_n = 1'b0;
    #1;
    check("midrun rst status", {o_run, o_done, o_valid, o_drives, o_rd, o_proto}, 6'b0);
    check("midrun rst data", o_data, 16'h0);
    @(negedge clk);
    check("midrun rst held", {o_run, o_valid, o_drives, o_rd}, 4'b0);
    arst_n = 1'b1;
    @(negedge clk);

    // Head backpressure for 5 cycles, then proto_err at K_BODY w=5.
    ready   = 1'b0;
    start_a = 1'b1;
    #1;
    check("bp c0 read", {o_rd, o_sel, o_addr}, 22'h200000);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      check($sformatf("bp stall c%0d valid/rd", k), {o_valid, o_drives, o_rd}, 3'b110);
      check($sformatf("bp stall c%0d data", k), o_data, 16'hA000);
    end
    ready = 1'b1;
    #1;
    check("bp accept read", {o_rd, o_sel, o_addr}, 22'h200001);
    for (int k = 7; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("bp c%0d body data", k), o_data, 16'hA000 | 16'(k - 6));
      if (k == 11) begin
        check("proto before", o_proto, 1'b0);
        ready = 1'b0;
      end
      if (k == 12) begin
        check("proto set", o_proto, 1'b1);
        ready = 1'b1;
      end
    end
    c    = 17;
    seen = 1'b0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      if (o_done) seen = 1'b1;
    end
    check("bp done cycle", c, 104);
    check("proto sticky", o_proto, 1'b1);

    // Wrap run X=2 Y=2 G=2 on the second instance.
    build_exp(2, 2, 2);
    run_stream(1'b1, 1'b0, "wrap");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
